// File: rtl/alu_mdu_controller_pkg.sv
// rtl/alu_mdu_controller_pkg.sv - shared constants and types for the EX-stage ALU/MDU controller
//
// Purpose: ALUOp encodings, ALU Operation codes, Funct7 markers, RV32M funct3
//          codes and the M-op sequencer state enum.
// Ports:   none (package).
package alu_pkg;

  // ALUOp from the main controller
  localparam logic [1:0] ALUOP_MEM    = 2'b00;  // LW/SW/AUIPC
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;  // R/I-type
  localparam logic [1:0] ALUOP_JUMP   = 2'b11;  // JAL/LUI

  // ALU Operation codes
  localparam logic [3:0] OP_AND    = 4'b0000;
  localparam logic [3:0] OP_XOR    = 4'b0001;
  localparam logic [3:0] OP_ADD    = 4'b0010;
  localparam logic [3:0] OP_OR     = 4'b0011;
  localparam logic [3:0] OP_SUB    = 4'b0100;
  localparam logic [3:0] OP_SRL    = 4'b0101;
  localparam logic [3:0] OP_SLL    = 4'b0110;
  localparam logic [3:0] OP_SRA    = 4'b0111;
  localparam logic [3:0] OP_BRANCH = 4'b1000;
  localparam logic [3:0] OP_PASSB  = 4'b1001;
  localparam logic [3:0] OP_SLTU   = 4'b1100;
  localparam logic [3:0] OP_SLT    = 4'b1101;

  // Funct7 markers
  localparam logic [6:0] F7_ALT  = 7'b0100000;  // SUB / SRA(I)
  localparam logic [6:0] F7_MEXT = 7'b0000001;  // RV32M

  // RV32M funct3
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } mdu_state_e;

  // Operand signedness per M funct3 (MUL low half is sign-agnostic)
  function automatic logic m_a_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic m_b_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/alu_mdu_controller_mdu_iter.sv
// rtl/alu_mdu_controller_mdu_iter.sv - iterative radix-2 multiply/divide datapath
//
// Purpose: captures operand magnitudes and signs on start, runs WIDTH
//          shift-add (multiply) or restoring (divide) steps, applies the
//          sign fix-up on the last step and presents the result with done.
// Ports:   clk, reset (async active-low), start (latch operands), abort
//          (drop the in-flight op), funct3, op_a, op_b (WIDTH);
//          done (high during the final step), result (WIDTH, valid with done).
module mdu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic             run;
  logic [CW-1:0]    cnt;
  // Upper half: product accumulator / partial remainder.
  // Lower half: multiplier bits still to consume / dividend shifting into quotient.
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;     // |SrcB|: multiplicand or divisor
  logic [2:0]       f3_q;
  logic             neg_res;   // negate product / quotient
  logic             neg_rem;   // remainder follows dividend sign

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;

  always_comb begin
    a_neg = m_a_signed(funct3) & op_a[WIDTH-1];
    b_neg = m_b_signed(funct3) & op_b[WIDTH-1];
    mag_a = a_neg ? (WIDTH'(0) - op_a) : op_a;
    mag_b = b_neg ? (WIDTH'(0) - op_b) : op_b;
  end

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shifted;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot, rem;

  always_comb begin
    // Shift-add: add multiplicand to the high half when the current LSB is set, then shift right.
    mul_sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
    // Restoring divide: shift in the next dividend bit, keep the difference if non-negative.
    div_shifted = acc[2*WIDTH-1:WIDTH-1];
    div_diff    = div_shifted - {1'b0, mcand};
    if (f3_q[2]) begin
      if (div_diff[WIDTH]) acc_next = {div_shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else                 acc_next = {div_diff[WIDTH-1:0],    acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_next = {mul_sum, acc[WIDTH-1:1]};
    end

    prod = neg_res ? ((2*WIDTH)'(0) - acc_next) : acc_next;
    quot = neg_res ? (WIDTH'(0) - acc_next[WIDTH-1:0]) : acc_next[WIDTH-1:0];
    rem  = neg_rem ? (WIDTH'(0) - acc_next[2*WIDTH-1:WIDTH]) : acc_next[2*WIDTH-1:WIDTH];

    case (f3_q)
      F3_MUL:                       result = prod[WIDTH-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: result = prod[2*WIDTH-1:WIDTH];
      F3_DIV, F3_DIVU:              result = quot;
      default:                      result = rem;
    endcase
  end

  assign done = run && (cnt == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run     <= 1'b0;
      cnt     <= '0;
      acc     <= '0;
      mcand   <= '0;
      f3_q    <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
    end else if (abort) begin
      run <= 1'b0;
    end else if (start) begin
      run     <= 1'b1;
      cnt     <= '0;
      acc     <= {{WIDTH{1'b0}}, mag_a};
      mcand   <= mag_b;
      f3_q    <= funct3;
      neg_res <= a_neg ^ b_neg;
      neg_rem <= a_neg;
    end else if (run) begin
      acc <= acc_next;
      cnt <= cnt + 1'b1;
      if (done) run <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mdu_controller.sv
// rtl/alu_mdu_controller.sv - EX-stage ALU decoder with RV32M multiply/divide sequencer
//
// Purpose: decodes ALUOp/Funct3/Funct7 into the ALU Operation code, detects
//          M-extension ops and runs them iteratively, stalling the pipeline.
// Ports:   clk, reset (async active-low), ALUOp[2], Funct7[7], Funct3[3],
//          InValid, SrcA/SrcB[WIDTH], Flush;
//          Operation[4] (comb), IsMOp (comb), Stall (comb),
//          MResult[WIDTH] (reg), MValid (reg, one-cycle pulse).
module alu_mdu_controller
  import alu_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter bit FAST_MUL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       ALUOp,
  input  logic [6:0]       Funct7,
  input  logic [2:0]       Funct3,
  input  logic             InValid,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic             Flush,
  output logic [3:0]       Operation,
  output logic             IsMOp,
  output logic             Stall,
  output logic [WIDTH-1:0] MResult,
  output logic             MValid
);

  mdu_state_e state;

  assign IsMOp = (ALUOp == ALUOP_RTYPE) && (Funct7 == F7_MEXT);

  always_comb begin
    Operation = OP_ADD;
    case (ALUOp)
      ALUOP_MEM:    Operation = OP_ADD;
      ALUOP_BRANCH: Operation = OP_BRANCH;
      ALUOP_JUMP:   Operation = OP_PASSB;
      default: begin
        if (!IsMOp) begin
          case (Funct3)
            3'b000:  Operation = (Funct7 == F7_ALT) ? OP_SUB : OP_ADD;
            3'b001:  Operation = OP_SLL;
            3'b010:  Operation = OP_SLT;
            3'b011:  Operation = OP_SLTU;
            3'b100:  Operation = OP_XOR;
            3'b101:  Operation = (Funct7 == F7_ALT) ? OP_SRA : OP_SRL;
            3'b110:  Operation = OP_OR;
            default: Operation = OP_AND;
          endcase
        end
      end
    endcase
  end

  logic accept;
  assign accept = (state == ST_IDLE) && InValid && IsMOp && !Flush;

  // Cases resolved without iterating: divide by zero and signed overflow
  logic             div_zero, div_ovf, special;
  logic [WIDTH-1:0] special_res;

  always_comb begin
    div_zero    = Funct3[2] && (SrcB == '0);
    div_ovf     = ((Funct3 == F3_DIV) || (Funct3 == F3_REM)) &&
                  (SrcA == {1'b1, {(WIDTH-1){1'b0}}}) && (SrcB == '1);
    special     = div_zero || div_ovf;
    special_res = '0;
    if (div_zero)     special_res = Funct3[1] ? SrcA : '1;
    else if (div_ovf) special_res = Funct3[1] ? '0 : SrcA;
  end

  logic             fast_hit;
  logic [WIDTH-1:0] fast_res;

  generate
    if (FAST_MUL) begin : g_fast
      logic [2*WIDTH-1:0] a_ext, b_ext, prod;
      // Sign-extending to 2*WIDTH makes the truncated product exact for every mix of signedness.
      assign a_ext    = {{WIDTH{m_a_signed(Funct3) & SrcA[WIDTH-1]}}, SrcA};
      assign b_ext    = {{WIDTH{m_b_signed(Funct3) & SrcB[WIDTH-1]}}, SrcB};
      assign prod     = a_ext * b_ext;
      assign fast_hit = !Funct3[2];
      assign fast_res = (Funct3 == F3_MUL) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
    end else begin : g_iter
      assign fast_hit = 1'b0;
      assign fast_res = '0;
    end
  endgenerate

  logic             mdu_start, mdu_done;
  logic [WIDTH-1:0] mdu_result;

  assign mdu_start = accept && !special && !fast_hit;

  mdu_iter #(.WIDTH(WIDTH)) u_mdu_iter (
    .clk    (clk),
    .reset  (reset),
    .start  (mdu_start),
    .abort  (Flush),
    .funct3 (Funct3),
    .op_a   (SrcA),
    .op_b   (SrcB),
    .done   (mdu_done),
    .result (mdu_result)
  );

  // Held low through reset so an M-op sitting in EX cannot stall while reset is asserted
  assign Stall = reset && (accept || ((state == ST_BUSY) && !Flush));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      MValid  <= 1'b0;
      MResult <= '0;
    end else begin
      MValid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (special) begin
              MResult <= special_res;
              MValid  <= 1'b1;
              state   <= ST_DONE;
            end else if (fast_hit) begin
              MResult <= fast_res;
              MValid  <= 1'b1;
              state   <= ST_DONE;
            end else begin
              state <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          if (Flush) begin
            state <= ST_IDLE;
          end else if (mdu_done) begin
            MResult <= mdu_result;
            MValid  <= 1'b1;
            state   <= ST_DONE;
          end
        end
        // The instruction is still in EX this cycle; returning to IDLE only after it moves on avoids a retrigger.
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mdu_controller.sv
// tb/tb_alu_mdu_controller.sv - directed self-checking bench for alu_mdu_controller
module tb_alu_mdu_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  ALUOp;
  logic [6:0]  Funct7;
  logic [2:0]  Funct3;
  logic        InValid;
  logic [31:0] SrcA, SrcB;
  logic        Flush;
  logic [3:0]  Operation;
  logic        IsMOp, Stall, MValid;
  logic [31:0] MResult;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu_mdu_controller #(.WIDTH(32), .FAST_MUL(1'b0)) dut (
    .clk       (clk),
    .reset     (reset),
    .ALUOp     (ALUOp),
    .Funct7    (Funct7),
    .Funct3    (Funct3),
    .InValid   (InValid),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .Flush     (Flush),
    .Operation (Operation),
    .IsMOp     (IsMOp),
    .Stall     (Stall),
    .MResult   (MResult),
    .MValid    (MValid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic decode(input string tag, input logic [1:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [3:0] exp_op);
    ALUOp = op; Funct3 = f3; Funct7 = f7; InValid = 1'b1;
    #1;
    chk({tag, "_op"}, {28'd0, Operation}, {28'd0, exp_op});
    chk({tag, "_stall"}, {31'd0, Stall}, 32'd0);
  endtask

  // Called just after a rising edge; returns at the falling edge of the cycle after DONE.
  task automatic run_mop(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_stall);
    int n;
    int early;
    ALUOp = 2'b10; Funct7 = 7'b0000001; Funct3 = f3; SrcA = a; SrcB = b; InValid = 1'b1;
    n = 0;
    early = 0;
    @(negedge clk);
    while (Stall === 1'b1 && n < 100) begin
      n++;
      if (MValid === 1'b1) early++;
      @(negedge clk);
    end
    chk({tag, "_stall_cycles"}, n, exp_stall);
    chk({tag, "_early_mvalid"}, early, 32'd0);
    chk({tag, "_mvalid"}, {31'd0, MValid}, 32'd1);
    chk({tag, "_result"}, MResult, exp);
    tick;
    InValid = 1'b0;
    @(negedge clk);
    chk({tag, "_single_pulse"}, {31'd0, MValid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; ALUOp = 2'b00; Funct7 = '0; Funct3 = '0; InValid = 1'b0;
    SrcA = '0; SrcB = '0; Flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", {31'd0, Stall}, 32'd0);
    chk("rst_mvalid", {31'd0, MValid}, 32'd0);
    chk("rst_mresult", MResult, 32'd0);
    tick;
    reset = 1'b1;

    decode("dec_add",  2'b10, 3'b000, 7'b0000000, 4'b0010);
    decode("dec_sub",  2'b10, 3'b000, 7'b0100000, 4'b0100);
    decode("dec_sll",  2'b10, 3'b001, 7'b0000000, 4'b0110);
    decode("dec_sra",  2'b10, 3'b101, 7'b0100000, 4'b0111);
    decode("dec_br",   2'b01, 3'b000, 7'b0000000, 4'b1000);
    decode("dec_pass", 2'b11, 3'b000, 7'b0000000, 4'b1001);
    decode("dec_mem",  2'b00, 3'b010, 7'b0000000, 4'b0010);
    ALUOp = 2'b10; Funct7 = 7'b0000001; Funct3 = 3'b000; InValid = 1'b0;
    #1;
    chk("dec_ismop", {31'd0, IsMOp}, 32'd1);
    chk("dec_mop_op", {28'd0, Operation}, 32'd2);
    tick;

    run_mop("mul",     3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);
    tick; run_mop("mulhu",   3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    tick; run_mop("mulh",    3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33);
    tick; run_mop("mulhsu",  3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
    tick; run_mop("div",     3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
    tick; run_mop("rem",     3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
    tick; run_mop("divu",    3'b101, 32'd100,      32'd7,        32'd14,       33);
    tick; run_mop("remu",    3'b111, 32'd100,      32'd7,        32'd2,        33);
    tick; run_mop("divu_z",  3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
    tick; run_mop("remu_z",  3'b111, 32'd5,        32'd0,        32'd5,        1);
    tick; run_mop("div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    tick; run_mop("rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);

    // Flush in BUSY cycle 10, then a fresh MUL right behind it
    tick;
    ALUOp = 2'b10; Funct7 = 7'b0000001; Funct3 = 3'b000; SrcA = 32'd3; SrcB = 32'd5; InValid = 1'b1;
    repeat (10) tick;
    Flush = 1'b1;
    @(negedge clk);
    chk("flush_stall", {31'd0, Stall}, 32'd0);
    chk("flush_mvalid", {31'd0, MValid}, 32'd0);
    tick;
    Flush = 1'b0;
    run_mop("mul_after_flush", 3'b000, 32'd9, 32'd11, 32'd99, 33);

    // Asynchronous reset in the middle of BUSY
    tick;
    ALUOp = 2'b10; Funct7 = 7'b0000001; Funct3 = 3'b000; SrcA = 32'd6; SrcB = 32'd7; InValid = 1'b1;
    repeat (5) tick;
    #2;
    reset = 1'b0;
    #1;
    chk("areset_stall", {31'd0, Stall}, 32'd0);
    chk("areset_mvalid", {31'd0, MValid}, 32'd0);
    chk("areset_mresult", MResult, 32'd0);
    InValid = 1'b0;
    tick;
    reset = 1'b1;
    @(negedge clk);
    chk("post_reset_stall", {31'd0, Stall}, 32'd0);
    tick;
    run_mop("mul_after_reset", 3'b000, 32'd6, 32'd7, 32'd42, 33);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_mdu_controller.md
# alu_mdu_controller

Parametrised EX-stage ALU controller with integrated RV32M multiply/divide sequencer. Decodes ALUOp/Funct3/Funct7 into the 4-bit single-cycle ALU Operation code, detects M-extension instructions and executes them iteratively over WIDTH bits. While an M-op is in flight it stalls the pipeline. Sits between the main Controller and the ALU/result mux in the EX stage.

## Interface
- WIDTH, 32: operand/result width; iterative latency scales with it.
- FAST_MUL, 0: 1 = MUL/MULH/MULHSU/MULHU use a registered full-width multiply (one-cycle result); 0 = iterative shift-add.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- ALUOp  in  2  00 LW/SW/AUIPC, 01 branch, 10 R/I-type, 11 JAL/LUI.
- Funct7  in  7  instruction[31:25].
- Funct3  in  3  instruction[14:12].
- InValid  in  1  a valid instruction occupies EX.
- SrcA, SrcB  in  WIDTH  ALU operands.
- Flush  in  1  abort any in-flight M-op.
- Operation  out  4  ALU operation code (combinational).
- IsMOp  out  1  ALUOp==10 && Funct7==0000001 (combinational).
- Stall  out  1  hold IF/ID/EX.
- MResult  out  WIDTH  M-op result, valid while MValid.
- MValid  out  1  one-cycle pulse, selects MResult into writeback.

## Operation
- Operation codes: AND 0000, XOR 0001, ADD 0010, OR 0011, SUB 0100, SRL 0101, SLL 0110, SRA 0111, BRANCH-CMP 1000, PASSB 1001, SLTU 1100, SLT 1101.
- ALUOp 00 → ADD; 01 → BRANCH-CMP; 11 → PASSB; 10 → by Funct3; Funct7=0100000 selects SUB (f3 000) / SRA (f3 101); I-type shifts use the same Funct7 field. For IsMOp, Operation = ADD (don't-care for the ALU).
- States: IDLE, BUSY, DONE.
- IDLE: InValid && IsMOp && !Flush → latch operands/funct3, Stall=1 this cycle. Next state BUSY, or DONE for special cases and FAST_MUL multiplies.
- Special cases (IDLE → DONE): divisor 0 → DIV/DIVU = all-ones, REM/REMU = dividend; DIV/REM with dividend = most-negative and divisor = −1 → quotient = most-negative, remainder = 0.
- BUSY: one radix-2 step per cycle for WIDTH cycles; iteration counter ⌈log2(WIDTH+1)⌉ bits. Multiply: 2·WIDTH-bit shift-add on magnitudes. Divide: restoring, on magnitudes.
- Sign fix-up on the final step: MULH signed×signed; MULHSU SrcA signed, SrcB unsigned; quotient negated if operand signs differ; remainder takes the dividend's sign.
- Result selection: MUL low half; MULH* high half.
- DONE: MValid=1, Stall=0, MResult registered. Always → IDLE.
- No new M-op is accepted in DONE. The same instruction is still presented that cycle and must not retrigger.
- Flush (any state): Stall=0 in that cycle, next state IDLE, no MValid. Flush in IDLE blocks acceptance.
- reset low: immediately IDLE; Stall=0, MValid=0, MResult=0, internal registers cleared.

## Timing
- Non-M ops: zero latency, Stall=0.
- Iterative M-op accepted at cycle 0: Stall high in cycles 0..WIDTH (WIDTH+1 cycles); DONE/MValid at cycle WIDTH+1.
- Special-case or FAST_MUL op: Stall high in cycle 0 only; MValid in cycle 1.
- Back-to-back M-ops: second accepted the cycle after DONE at the earliest.
- Stall is combinational from state plus inputs. MValid and MResult are registered.

## Structure
- Package alu_pkg holds:
  - ALUOp constants;
  - Operation code localparams;
  - M funct3 codes (MUL 000, MULH 001, MULHSU 010, MULHU 011, DIV 100, DIVU 101, REM 110, REMU 111);
  - state enum.
- Sub-module mdu_iter: operand magnitude/sign capture, shift-add/restoring datapath, iteration counter, fix-up. Handshake: start, done, result.
- The top level keeps the decoder, FSM, special-case detect and the FAST_MUL generate branch.

## Test plan
- Decode: ALUOp=10, F3=000, F7=0000000 → Operation 0010; F7=0100000 → 0100; F3=001 → 0110; F3=101, F7=0100000 → 0111; ALUOp=01 → 1000; all with Stall=0.
- MUL, WIDTH=32, FAST_MUL=0: SrcA=7, SrcB=0xFFFFFFFD → Stall 33 cycles, then MValid pulse with MResult=0xFFFFFFEB, then IDLE.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULH same operands → 0x00000000. MULHSU → 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 → 0xFFFFFFFD; REM → 0xFFFFFFFF; DIVU 5/0 → 0xFFFFFFFF after a 1-cycle stall; DIV 0x80000000/0xFFFFFFFF → 0x80000000, REM → 0.
- Flush asserted in BUSY cycle 10 → Stall=0 that cycle, no MValid ever, IDLE next; a new MUL accepted immediately afterwards completes correctly.
- reset low in BUSY → Stall/MValid/MResult 0 asynchronously. InValid held across DONE → exactly one MValid pulse.
